// File: rtl/timer_pkg.sv
// Shared types and defaults for the interval timer: controller state
// encoding and the default counter width.
package timer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : timer_pkg

// File: rtl/down_counter_cell.sv
// One bit of the down-counter: toggles on incoming borrow, passes a borrow
// upward when it toggles from 0, and can be parallel-loaded.
module down_counter_cell (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic d,
  input  logic bin,
  output logic q,
  output logic bout
);

  logic q_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else if (load) begin
      q_q <= d;
    end else if (bin) begin
      q_q <= ~q_q;
    end
  end

  assign q    = q_q;
  assign bout = bin & ~q_q;

endmodule : down_counter_cell

// File: rtl/interval_timer.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
// A two-state controller drives a ripple-borrow array of counter cells.
module interval_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  logic             terminal;
  logic             cell_load;
  logic [WIDTH-1:0] cell_d;
  logic [WIDTH:0]   borrow_chain;
  logic             borrow_unused;

  assign busy = (state_q == RUN);
  assign tc   = tc_q;

  // The terminal step is not a decrement: the cells are loaded with either
  // the period or zero, so the borrow chain stays quiet on that cycle.
  assign terminal        = busy & en & (count == WIDTH'(1));
  assign cell_load       = load | terminal;
  assign borrow_chain[0] = busy & en & (count != WIDTH'(1));
  assign borrow_unused   = borrow_chain[WIDTH];

  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    cell_d   = '0;
    if (load) begin
      cell_d   = load_val;
      reload_d = load_val;
      state_d  = (load_val != '0) ? RUN : IDLE;
    end else if (terminal) begin
      tc_d = 1'b1;
      if (auto_reload) begin
        cell_d = reload_q;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      down_counter_cell u_cell (
        .clk  (clk),
        .rst  (rst),
        .load (cell_load),
        .d    (cell_d[gi]),
        .bin  (borrow_chain[gi]),
        .q    (count[gi]),
        .bout (borrow_chain[gi+1])
      );
    end
  endgenerate

endmodule : interval_timer
